// File: rtl/mem_cpu_port_arb.sv
// Round-robin arbiter sharing the memory controller's single CPU request port.
// Optional REQ-state abort: define MEM_CPU_ARB_TIMEOUT_EN.
module mem_cpu_port_arb #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned ADDR_WIDTH     = 8,
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                          clockCore,
   input  logic                          resetCore,
   input  logic [NUM_REQ-1:0]            reqVld,
   input  logic [NUM_REQ-1:0]            reqRd,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] reqAddr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] reqWrData,
   output logic [NUM_REQ-1:0]            reqAck,
   output logic                          reqErr,
   output logic [DATA_WIDTH-1:0]         reqRdData,
   output logic                          cpuMemReq,
   output logic                          cpuMemRd,
   output logic [ADDR_WIDTH-1:0]         cpuMemAddr,
   output logic [DATA_WIDTH-1:0]         cpuMemWrData,
   input  logic                          cpuMemAck,
   input  logic [DATA_WIDTH-1:0]         cpuMemRdData,
   output logic                          busy
);
   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, REQ, GAP1, GAP2} state_t;

   state_t           state;
   logic [IDX_W-1:0] rrPtr;
   logic [IDX_W-1:0] grantIdx;
   logic [IDX_W-1:0] nextGrant;
   logic [IDX_W-1:0] nextPtr;
   logic             anyReq;

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : gBadParam
      $error("mem_cpu_port_arb: parameter out of range");
   end

   // First requesting index at or above the pointer, wrapping around.
   always_comb begin
      logic [IDX_W-1:0] candIdx;
      candIdx   = '0;
      anyReq    = 1'b0;
      nextGrant = '0;
      nextPtr   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         candIdx = IDX_W'((32'(rrPtr) + i) % NUM_REQ);
         if (!anyReq && reqVld[candIdx]) begin
            anyReq    = 1'b1;
            nextGrant = candIdx;
            nextPtr   = IDX_W'((32'(candIdx) + 1) % NUM_REQ);
         end
      end
   end

`ifdef MEM_CPU_ARB_TIMEOUT_EN
   logic [15:0] toCnt;
`else
   assign reqErr = 1'b0;
`endif

   always_ff @(posedge clockCore or negedge resetCore) begin
      if (!resetCore) begin
         state        <= IDLE;
         rrPtr        <= '0;
         grantIdx     <= '0;
         reqAck       <= '0;
         reqRdData    <= '0;
         cpuMemReq    <= 1'b0;
         cpuMemRd     <= 1'b0;
         cpuMemAddr   <= '0;
         cpuMemWrData <= '0;
         busy         <= 1'b0;
`ifdef MEM_CPU_ARB_TIMEOUT_EN
         toCnt        <= '0;
         reqErr       <= 1'b0;
`endif
      end else begin
         reqAck <= '0;
         case (state)
            IDLE: begin
               if (anyReq) begin
                  state        <= REQ;
                  grantIdx     <= nextGrant;
                  rrPtr        <= nextPtr;
                  cpuMemReq    <= 1'b1;
                  busy         <= 1'b1;
                  cpuMemRd     <= reqRd[nextGrant];
                  cpuMemAddr   <= reqAddr[nextGrant*ADDR_WIDTH +: ADDR_WIDTH];
                  cpuMemWrData <= reqWrData[nextGrant*DATA_WIDTH +: DATA_WIDTH];
`ifdef MEM_CPU_ARB_TIMEOUT_EN
                  toCnt        <= '0;
`endif
               end
            end
            REQ: begin
               // Ack takes priority over a coincident timeout.
               if (cpuMemAck) begin
                  state            <= GAP1;
                  cpuMemReq        <= 1'b0;
                  reqAck[grantIdx] <= 1'b1;
                  if (cpuMemRd) begin
                     reqRdData <= cpuMemRdData;
                  end
               end
`ifdef MEM_CPU_ARB_TIMEOUT_EN
               else if (toCnt == 16'(TIMEOUT_CYCLES - 1)) begin
                  state            <= GAP1;
                  cpuMemReq        <= 1'b0;
                  reqAck[grantIdx] <= 1'b1;
                  reqRdData        <= '1;
                  reqErr           <= 1'b1;
               end else begin
                  toCnt <= toCnt + 16'd1;
               end
`endif
            end
            GAP1: begin
               state <= GAP2;
`ifdef MEM_CPU_ARB_TIMEOUT_EN
               reqErr <= 1'b0;
`endif
            end
            GAP2: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
